// File: rtl/moore_seq_gen.sv
// rtl/moore_seq_gen.sv - Moore serial pattern generator, MSB-first frames repeated reps times then a done pulse.
// Outputs are registered from the next-state values, so they change only on a clock edge or reset.
module moore_seq_gen #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] reps,
   output logic             outbit,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [REP_W-1:0]   frame_q, frame_d;
   logic               outbit_q, outbit_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [LEN_W-1:0]   len_eff;
   logic [REP_W-1:0]   reps_eff;

   // Out-of-range lengths and zero repeat counts fall back to a full single frame.
   always_comb begin
      len_eff = len;
      if (len == '0 || len > LEN_W'(PAT_W)) begin
         len_eff = LEN_W'(PAT_W);
      end
      reps_eff = reps;
      if (reps == '0) begin
         reps_eff = REP_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      len_d   = len_q;
      frame_d = frame_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               pat_d   = pattern;
               len_d   = len_eff;
               idx_d   = len_eff - LEN_W'(1);
               frame_d = reps_eff - REP_W'(1);
               state_d = S_SEND;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (idx_q != '0) begin
               idx_d = idx_q - LEN_W'(1);
            end else if (frame_q != '0) begin
               frame_d = frame_q - REP_W'(1);
               idx_d   = len_q - LEN_W'(1);
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d == S_SEND);
      valid_d  = (state_d == S_SEND);
      done_d   = (state_d == S_DONE);
      outbit_d = (state_d == S_SEND) && |(pat_d & (PAT_W'(1) << idx_d));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pat_q    <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         frame_q  <= '0;
         outbit_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         frame_q  <= frame_d;
         outbit_q <= outbit_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign outbit = outbit_q;
   assign valid  = valid_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// tb/tb_moore_seq_gen.sv - Vector-table and scoreboard bench for moore_seq_gen.
module tb_moore_seq_gen;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] reps;
   logic       outbit;
   logic       valid;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;
   logic exp_q[$];

   typedef struct {
      logic [7:0] pat;
      logic [3:0] len;
      logic [3:0] reps;
      int         exp_len;
      int         exp_reps;
      bit         disturb;
      bit         chain;
   } vec_t;

   vec_t vecs[8];

   moore_seq_gen #(.PAT_W(8), .LEN_W(4), .REP_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .reps    (reps),
      .outbit  (outbit),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_outbit"}, outbit, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic drive_start(input vec_t v);
      start   = 1'b1;
      pattern = v.pat;
      len     = v.len;
      reps    = v.reps;
   endtask

   task automatic push_model(input vec_t v);
      for (int f = 0; f < v.exp_reps; f++)
         for (int b = v.exp_len - 1; b >= 0; b--)
            exp_q.push_back(v.pat[b]);
   endtask

   // Pops one expected bit per cycle; queue length bounds the loop.
   task automatic consume(input bit disturb);
      logic e;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check("bit_valid", valid, 1);
         check("bit_busy", busy, 1);
         check("bit_done", done, 0);
         check("bit_outbit", outbit, e);
         if (disturb) begin
            start   = 1'($urandom_range(0, 1));
            pattern = 8'($urandom);
            len     = 4'($urandom);
            reps    = 4'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      bit pending;
      start   = 1'b0;
      pattern = '0;
      len     = '0;
      reps    = '0;
      reset   = 1'b0;

      vecs[0] = '{8'h05, 4'd3,  4'd3,  3, 3,  1'b0, 1'b0};
      vecs[1] = '{8'hA5, 4'd8,  4'd1,  8, 1,  1'b0, 1'b0};
      vecs[2] = '{8'h81, 4'd0,  4'd0,  8, 1,  1'b0, 1'b0};
      vecs[3] = '{8'h3C, 4'd12, 4'd2,  8, 2,  1'b0, 1'b0};
      vecs[4] = '{8'h01, 4'd1,  4'd15, 1, 15, 1'b0, 1'b0};
      vecs[5] = '{8'hC6, 4'd5,  4'd2,  5, 2,  1'b1, 1'b0};
      vecs[6] = '{8'h05, 4'd3,  4'd1,  3, 1,  1'b0, 1'b1};
      vecs[7] = '{8'h06, 4'd3,  4'd1,  3, 1,  1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check_quiet("reset_hold");
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_quiet("idle_no_start");
      end

      // Asynchronous reset in the middle of a frame, between clock edges.
      drive_start('{8'hFF, 4'd8, 4'd2, 8, 2, 1'b0, 1'b0});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", valid, 1);
      check("pre_reset_outbit", outbit, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_quiet("async_reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_quiet("post_reset_idle");
      end

      pending = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!pending) drive_start(vecs[i]);
         push_model(vecs[i]);
         consume(vecs[i].disturb);
         @(negedge clk);
         check("done_pulse", done, 1);
         check("done_busy", busy, 0);
         check("done_valid", valid, 0);
         check("done_outbit", outbit, 0);
         if (vecs[i].chain && i + 1 < 8) begin
            drive_start(vecs[i+1]);
            pending = 1'b1;
         end else begin
            start   = 1'b0;
            pending = 1'b0;
            @(negedge clk);
            check_quiet("after_done");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
